// File: rtl/img_rx_unpack.sv
// rtl/img_rx_unpack.sv - UART byte stream to image pixel unpacker with header, checksum tail and timeout
//
// Frame layout: header (width then height, each DIM_W/8 bytes MSB first),
// width*height pixels of BPP bytes each (MSB first), one tail byte holding
// the mod-256 sum of all pixel bytes.
//
// Ports:
//   i_clk_sys, i_rst_n      clock, asynchronous active-low reset
//   i_rx_data, i_rx_done    received byte and its one-cycle strobe
//   i_start, i_abort        frame start / abort pulses (abort > start > byte)
//   o_state                 IDLE=0, HDR=1, PIX=2, TAIL=3
//   o_width, o_height       latched dimensions, o_hdr_valid level
//   o_pix, o_pix_x, o_pix_y assembled pixel and its raster coordinate
//   o_pix_valid             pixel strobe
//   o_check_code            bits {7,4,3,0} of each pixel byte, first byte on top
//   o_check_valid           strobe coincident with o_pix_valid
//   o_frame_done            strobe: tail matched the running sum
//   o_err_code              sticky: 0 none, 1 timeout, 2 checksum, 3 abort
module img_rx_unpack #(
    parameter int PIX_W       = 12,
    parameter int BPP         = 2,
    parameter int DIM_W       = 8,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic               i_clk_sys,
    input  logic               i_rst_n,
    input  logic [7:0]         i_rx_data,
    input  logic               i_rx_done,
    input  logic               i_start,
    input  logic               i_abort,
    output logic [2:0]         o_state,
    output logic [DIM_W-1:0]   o_width,
    output logic [DIM_W-1:0]   o_height,
    output logic               o_hdr_valid,
    output logic [PIX_W-1:0]   o_pix,
    output logic [DIM_W-1:0]   o_pix_x,
    output logic [DIM_W-1:0]   o_pix_y,
    output logic               o_pix_valid,
    output logic [4*BPP-1:0]   o_check_code,
    output logic               o_check_valid,
    output logic               o_frame_done,
    output logic [1:0]         o_err_code
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_PIX  = 3'd2,
        S_TAIL = 3'd3
    } state_t;

    localparam int          HDR_BYTES = 2 * DIM_W / 8;
    localparam int          WORD_W    = 8 * BPP;
    localparam logic [31:0] TO_LAST   = (TIMEOUT_CYC > 0) ? 32'(TIMEOUT_CYC - 1) : 32'd0;

    state_t                 state, state_nx;
    logic [2:0]             byte_cnt;
    logic [WORD_W-1:0]      acc, pix_word;
    logic [2*DIM_W-1:0]     hdr_buf, hdr_word;
    logic [DIM_W-1:0]       cnt_x, cnt_y;
    logic [7:0]             sum;
    logic [31:0]            to_cnt;
    logic                   byte_ok, timeout_hit, hdr_last, pix_last, x_last, coord_last, dim_zero;

    function automatic logic [PIX_W-1:0] pix_of(input logic [WORD_W-1:0] w);
        return w[WORD_W-1 -: PIX_W];
    endfunction

    function automatic logic [4*BPP-1:0] chk_of(input logic [WORD_W-1:0] w);
        logic [4*BPP-1:0] c;
        for (int i = 0; i < BPP; i++)
            c[4*i +: 4] = {w[8*i+7], w[8*i+4], w[8*i+3], w[8*i]};
        return c;
    endfunction

    assign o_state = state;

    // Bytes coincident with start/abort are dropped.
    assign byte_ok     = i_rx_done && !i_start && !i_abort;
    assign timeout_hit = (TIMEOUT_CYC != 0) && (state != S_IDLE) && !byte_ok && (to_cnt == TO_LAST);
    assign hdr_last    = (byte_cnt == 3'(HDR_BYTES - 1));
    assign pix_last    = (byte_cnt == 3'(BPP - 1));
    assign x_last      = (cnt_x == o_width - DIM_W'(1));
    assign coord_last  = x_last && (cnt_y == o_height - DIM_W'(1));
    assign dim_zero    = (hdr_word[2*DIM_W-1:DIM_W] == '0) || (hdr_word[DIM_W-1:0] == '0);

    // The final byte of a header/pixel is used straight from the input so the
    // completed word is available in the same cycle as its last strobe.
    always_comb begin
        pix_word      = acc;
        pix_word[7:0] = i_rx_data;
        hdr_word      = hdr_buf;
        hdr_word[7:0] = i_rx_data;
    end

    always_comb begin
        state_nx = state;
        if (i_abort && state != S_IDLE) begin
            state_nx = S_IDLE;
        end else if (i_start) begin
            state_nx = S_HDR;
        end else if (timeout_hit) begin
            state_nx = S_IDLE;
        end else if (byte_ok) begin
            case (state)
                S_HDR:   if (hdr_last) state_nx = dim_zero ? S_TAIL : S_PIX;
                S_PIX:   if (pix_last && coord_last) state_nx = S_TAIL;
                S_TAIL:  state_nx = S_IDLE;
                default: state_nx = state;
            endcase
        end
    end

    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) state <= S_IDLE;
        else          state <= state_nx;
    end

    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            byte_cnt      <= '0;
            acc           <= '0;
            hdr_buf       <= '0;
            cnt_x         <= '0;
            cnt_y         <= '0;
            sum           <= '0;
            to_cnt        <= '0;
            o_width       <= '0;
            o_height      <= '0;
            o_hdr_valid   <= 1'b0;
            o_pix         <= '0;
            o_pix_x       <= '0;
            o_pix_y       <= '0;
            o_pix_valid   <= 1'b0;
            o_check_code  <= '0;
            o_check_valid <= 1'b0;
            o_frame_done  <= 1'b0;
            o_err_code    <= 2'd0;
        end else begin
            o_pix_valid   <= 1'b0;
            o_check_valid <= 1'b0;
            o_frame_done  <= 1'b0;

            if (i_start || byte_ok || state == S_IDLE) to_cnt <= '0;
            else if (TIMEOUT_CYC != 0)                 to_cnt <= to_cnt + 32'd1;

            if (i_abort && state != S_IDLE) begin
                o_err_code <= 2'd3;
                byte_cnt   <= '0;
            end else if (i_start) begin
                byte_cnt    <= '0;
                cnt_x       <= '0;
                cnt_y       <= '0;
                sum         <= '0;
                o_hdr_valid <= 1'b0;
                o_err_code  <= 2'd0;
            end else if (timeout_hit) begin
                o_err_code <= 2'd1;
                byte_cnt   <= '0;
            end else if (byte_ok) begin
                case (state)
                    S_HDR: begin
                        for (int i = 0; i < HDR_BYTES; i++)
                            if (byte_cnt == 3'(HDR_BYTES - 1 - i)) hdr_buf[8*i +: 8] <= i_rx_data;
                        if (hdr_last) begin
                            o_width     <= hdr_word[2*DIM_W-1:DIM_W];
                            o_height    <= hdr_word[DIM_W-1:0];
                            o_hdr_valid <= 1'b1;
                            byte_cnt    <= '0;
                        end else begin
                            byte_cnt <= byte_cnt + 3'd1;
                        end
                    end
                    S_PIX: begin
                        sum <= sum + i_rx_data;
                        for (int i = 0; i < BPP; i++)
                            if (byte_cnt == 3'(BPP - 1 - i)) acc[8*i +: 8] <= i_rx_data;
                        if (pix_last) begin
                            o_pix         <= pix_of(pix_word);
                            o_check_code  <= chk_of(pix_word);
                            o_pix_x       <= cnt_x;
                            o_pix_y       <= cnt_y;
                            o_pix_valid   <= 1'b1;
                            o_check_valid <= 1'b1;
                            byte_cnt      <= '0;
                            if (x_last) begin
                                cnt_x <= '0;
                                cnt_y <= cnt_y + DIM_W'(1);
                            end else begin
                                cnt_x <= cnt_x + DIM_W'(1);
                            end
                        end else begin
                            byte_cnt <= byte_cnt + 3'd1;
                        end
                    end
                    S_TAIL: begin
                        if (i_rx_data == sum) o_frame_done <= 1'b1;
                        else                  o_err_code   <= 2'd2;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_img_rx_unpack.sv
// tb/tb_img_rx_unpack.sv - scoreboard bench for img_rx_unpack (two parameterisations)
module tb_img_rx_unpack;

    localparam int TO = 64;

    typedef struct {
        int pix;
        int x;
        int y;
        int chk;
    } exp_t;
    typedef logic [7:0] bq_t[$];

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data [2];
    logic       rx_done [2];
    logic       start   [2];
    logic       abort   [2];

    logic [2:0]  a_state, b_state;
    logic [7:0]  a_width, a_height, a_pix_x, a_pix_y, a_check;
    logic [15:0] b_width, b_height, b_pix_x, b_pix_y;
    logic [3:0]  b_check;
    logic [11:0] a_pix;
    logic [7:0]  b_pix;
    logic        a_hdr_valid, a_pix_valid, a_check_valid, a_frame_done;
    logic        b_hdr_valid, b_pix_valid, b_check_valid, b_frame_done;
    logic [1:0]  a_err, b_err;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   done_cnt [2];
    exp_t exp_a[$];
    exp_t exp_b[$];
    exp_t ea, eb;

    always #5 clk = ~clk;

    img_rx_unpack #(.PIX_W(12), .BPP(2), .DIM_W(8), .TIMEOUT_CYC(TO)) dut_a (
        .i_clk_sys(clk), .i_rst_n(rst_n), .i_rx_data(rx_data[0]), .i_rx_done(rx_done[0]),
        .i_start(start[0]), .i_abort(abort[0]), .o_state(a_state), .o_width(a_width),
        .o_height(a_height), .o_hdr_valid(a_hdr_valid), .o_pix(a_pix), .o_pix_x(a_pix_x),
        .o_pix_y(a_pix_y), .o_pix_valid(a_pix_valid), .o_check_code(a_check),
        .o_check_valid(a_check_valid), .o_frame_done(a_frame_done), .o_err_code(a_err)
    );

    img_rx_unpack #(.PIX_W(8), .BPP(1), .DIM_W(16), .TIMEOUT_CYC(TO)) dut_b (
        .i_clk_sys(clk), .i_rst_n(rst_n), .i_rx_data(rx_data[1]), .i_rx_done(rx_done[1]),
        .i_start(start[1]), .i_abort(abort[1]), .o_state(b_state), .o_width(b_width),
        .o_height(b_height), .o_hdr_valid(b_hdr_valid), .o_pix(b_pix), .o_pix_x(b_pix_x),
        .o_pix_y(b_pix_y), .o_pix_valid(b_pix_valid), .o_check_code(b_check),
        .o_check_valid(b_check_valid), .o_frame_done(b_frame_done), .o_err_code(b_err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int f_state(input int sel);
        return sel != 0 ? int'(b_state) : int'(a_state);
    endfunction
    function automatic int f_err(input int sel);
        return sel != 0 ? int'(b_err) : int'(a_err);
    endfunction
    function automatic int f_width(input int sel);
        return sel != 0 ? int'(b_width) : int'(a_width);
    endfunction
    function automatic int f_height(input int sel);
        return sel != 0 ? int'(b_height) : int'(a_height);
    endfunction
    function automatic int f_hdr(input int sel);
        return sel != 0 ? int'(b_hdr_valid) : int'(a_hdr_valid);
    endfunction
    function automatic int f_pending(input int sel);
        return sel != 0 ? exp_b.size() : exp_a.size();
    endfunction

    function automatic int chk_nib(input int b);
        return ((b >> 7) & 1) * 8 + ((b >> 4) & 1) * 4 + ((b >> 3) & 1) * 2 + (b & 1);
    endfunction

    function automatic void push_exp(input int sel, input int pix, input int x, input int y, input int chk);
        exp_t e;
        e.pix = pix; e.x = x; e.y = y; e.chk = chk;
        if (sel != 0) exp_b.push_back(e);
        else          exp_a.push_back(e);
    endfunction

    // Reference model: parses the frame byte list with plain arithmetic.
    task automatic model_frame(input int sel, input bq_t fb, output int e_err, output int e_done,
                               output int e_w, output int e_h);
        int nd, bpp, pixw, idx, sum, word, c, b;
        nd   = (sel != 0) ? 2 : 1;
        bpp  = (sel != 0) ? 1 : 2;
        pixw = (sel != 0) ? 8 : 12;
        e_w = 0; e_h = 0; sum = 0;
        for (int i = 0; i < nd; i++) e_w = e_w * 256 + int'(fb[i]);
        for (int i = 0; i < nd; i++) e_h = e_h * 256 + int'(fb[nd + i]);
        idx = 2 * nd;
        for (int p = 0; p < e_w * e_h; p++) begin
            word = 0; c = 0;
            for (int k = 0; k < bpp; k++) begin
                b    = int'(fb[idx]);
                word = word * 256 + b;
                c    = c * 16 + chk_nib(b);
                sum  = (sum + b) % 256;
                idx++;
            end
            push_exp(sel, word >> (8 * bpp - pixw), p % e_w, p / e_w, c);
        end
        e_done = (int'(fb[idx]) == sum) ? 1 : 0;
        e_err  = (e_done != 0) ? 0 : 2;
    endtask

    function automatic bq_t rand_frame(input int sel);
        bq_t q;
        int  w, h, sum, b, nbytes;
        w = int'($urandom_range(0, 4));
        h = int'($urandom_range(1, 3));
        if (sel != 0) q.push_back(8'h00);
        q.push_back(8'(w));
        if (sel != 0) q.push_back(8'h00);
        q.push_back(8'(h));
        nbytes = w * h * ((sel != 0) ? 1 : 2);
        sum = 0;
        for (int i = 0; i < nbytes; i++) begin
            b = int'($urandom_range(0, 255));
            q.push_back(8'(b));
            sum += b;
        end
        if ($urandom_range(0, 3) != 0) q.push_back(8'(sum));
        else                           q.push_back(8'(sum + 1 + int'($urandom_range(0, 254))));
        return q;
    endfunction

    task automatic send_byte(input int sel, input logic [7:0] b);
        @(posedge clk); #1;
        rx_data[sel] = b;
        rx_done[sel] = 1'b1;
        @(posedge clk); #1;
        rx_done[sel] = 1'b0;
    endtask

    task automatic pulse_start(input int sel, input bit coincident);
        @(posedge clk); #1;
        start[sel] = 1'b1;
        if (coincident) begin
            rx_data[sel] = 8'h77;
            rx_done[sel] = 1'b1;
        end
        @(posedge clk); #1;
        start[sel]   = 1'b0;
        rx_done[sel] = 1'b0;
    endtask

    task automatic pulse_abort(input int sel);
        @(posedge clk); #1;
        abort[sel] = 1'b1;
        @(posedge clk); #1;
        abort[sel] = 1'b0;
    endtask

    task automatic run_frame(input int sel, input bq_t fb, input string tag, input bit coincident,
                             input int e_err, input int e_done, input int e_w, input int e_h);
        int d0;
        d0 = done_cnt[sel];
        pulse_start(sel, coincident);
        foreach (fb[i]) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            send_byte(sel, fb[i]);
        end
        repeat (3) @(posedge clk);
        #1;
        check({tag, " frame_done count"}, 64'(done_cnt[sel] - d0), 64'(e_done));
        check({tag, " err_code"}, 64'(f_err(sel)), 64'(e_err));
        check({tag, " state"}, 64'(f_state(sel)), 64'd0);
        check({tag, " width"}, 64'(f_width(sel)), 64'(e_w));
        check({tag, " height"}, 64'(f_height(sel)), 64'(e_h));
        check({tag, " hdr_valid"}, 64'(f_hdr(sel)), 64'd1);
        check({tag, " pixels outstanding"}, 64'(f_pending(sel)), 64'd0);
    endtask

    task automatic run_random(input int sel, input string tag);
        bq_t fb;
        int  e_err, e_done, e_w, e_h;
        fb = rand_frame(sel);
        model_frame(sel, fb, e_err, e_done, e_w, e_h);
        run_frame(sel, fb, tag, 1'b0, e_err, e_done, e_w, e_h);
    endtask

    always @(negedge clk) begin
        if (a_frame_done) done_cnt[0]++;
        if (a_pix_valid) begin
            if (exp_a.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL a pixel unexpected: got %0h at (%0d,%0d), expected no pixel", a_pix, a_pix_x, a_pix_y);
            end else begin
                ea = exp_a.pop_front();
                check("a pix", 64'(a_pix), 64'(ea.pix));
                check("a pix_x", 64'(a_pix_x), 64'(ea.x));
                check("a pix_y", 64'(a_pix_y), 64'(ea.y));
                check("a check_code", 64'(a_check), 64'(ea.chk));
                check("a check_valid", 64'(a_check_valid), 64'd1);
            end
        end
    end

    always @(negedge clk) begin
        if (b_frame_done) done_cnt[1]++;
        if (b_pix_valid) begin
            if (exp_b.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL b pixel unexpected: got %0h at (%0d,%0d), expected no pixel", b_pix, b_pix_x, b_pix_y);
            end else begin
                eb = exp_b.pop_front();
                check("b pix", 64'(b_pix), 64'(eb.pix));
                check("b pix_x", 64'(b_pix_x), 64'(eb.x));
                check("b pix_y", 64'(b_pix_y), 64'(eb.y));
                check("b check_code", 64'(b_check), 64'(eb.chk));
                check("b check_valid", 64'(b_check_valid), 64'd1);
            end
        end
    end

    initial begin
        for (int s = 0; s < 2; s++) begin
            rx_data[s] = 8'h00; rx_done[s] = 1'b0; start[s] = 1'b0; abort[s] = 1'b0;
            done_cnt[s] = 0;
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("reset a state", 64'(a_state), 64'd0);
        check("reset a width", 64'(a_width), 64'd0);
        check("reset a hdr_valid", 64'(a_hdr_valid), 64'd0);
        check("reset a err", 64'(a_err), 64'd0);
        check("reset a pix", 64'(a_pix), 64'd0);
        check("reset b state", 64'(b_state), 64'd0);

        // Bytes in IDLE are ignored.
        send_byte(0, 8'h55);
        check("idle byte ignored", 64'(a_state), 64'd0);

        // Nominal frame.
        push_exp(0, 'hA5F, 0, 0, 'h9C);
        push_exp(0, 'h123, 1, 0, 'h44);
        run_frame(0, '{8'h02, 8'h01, 8'hA5, 8'hF0, 8'h12, 8'h34, 8'hDB}, "nominal", 1'b0, 0, 1, 2, 1);

        // Bad tail.
        push_exp(0, 'hA5F, 0, 0, 'h9C);
        push_exp(0, 'h123, 1, 0, 'h44);
        run_frame(0, '{8'h02, 8'h01, 8'hA5, 8'hF0, 8'h12, 8'h34, 8'h00}, "bad tail", 1'b0, 2, 0, 2, 1);

        // Zero width: straight to tail.
        run_frame(0, '{8'h00, 8'h05, 8'h00}, "zero width", 1'b0, 0, 1, 0, 5);

        // Byte coincident with start is dropped.
        push_exp(0, 'hA5F, 0, 0, 'h9C);
        push_exp(0, 'h123, 1, 0, 'h44);
        run_frame(0, '{8'h02, 8'h01, 8'hA5, 8'hF0, 8'h12, 8'h34, 8'hDB}, "coincident", 1'b1, 0, 1, 2, 1);

        // Abort in IDLE has no effect.
        pulse_abort(0);
        check("idle abort err", 64'(a_err), 64'd0);
        check("idle abort state", 64'(a_state), 64'd0);

        // Timeout with a partial pixel.
        pulse_start(0, 1'b0);
        send_byte(0, 8'h02); send_byte(0, 8'h01); send_byte(0, 8'hA5);
        repeat (TO - 2) @(posedge clk);
        #1;
        check("timeout not early", 64'(a_state), 64'd2);
        repeat (4) @(posedge clk);
        #1;
        check("timeout state", 64'(a_state), 64'd0);
        check("timeout err", 64'(a_err), 64'd1);

        // Abort mid-pixel.
        pulse_start(0, 1'b0);
        send_byte(0, 8'h02); send_byte(0, 8'h01); send_byte(0, 8'hA5);
        pulse_abort(0);
        #1;
        check("abort err", 64'(a_err), 64'd3);
        check("abort state", 64'(a_state), 64'd0);

        // Restart mid-frame: stale partial byte must not leak.
        pulse_start(0, 1'b0);
        send_byte(0, 8'h02); send_byte(0, 8'h01); send_byte(0, 8'hEE);
        push_exp(0, 'hA5F, 0, 0, 'h9C);
        push_exp(0, 'h123, 1, 0, 'h44);
        run_frame(0, '{8'h02, 8'h01, 8'hA5, 8'hF0, 8'h12, 8'h34, 8'hDB}, "restart", 1'b0, 0, 1, 2, 1);

        // Byte-per-pixel, 16-bit dimensions.
        push_exp(1, 'h11, 0, 0, 'h5);
        push_exp(1, 'h22, 1, 0, 'h0);
        push_exp(1, 'h33, 2, 0, 'h5);
        run_frame(1, '{8'h00, 8'h03, 8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h66}, "bpp1", 1'b0, 0, 1, 3, 1);

        for (int n = 0; n < 12; n++) begin
            run_random(0, "rand a");
            run_random(1, "rand b");
        end

        // Asynchronous reset during PIX.
        pulse_start(0, 1'b0);
        send_byte(0, 8'h02); send_byte(0, 8'h01); send_byte(0, 8'hA5);
        #2 rst_n = 1'b0;
        #1;
        check("async rst state", 64'(a_state), 64'd0);
        check("async rst width", 64'(a_width), 64'd0);
        check("async rst height", 64'(a_height), 64'd0);
        check("async rst hdr_valid", 64'(a_hdr_valid), 64'd0);
        check("async rst pix", 64'(a_pix), 64'd0);
        check("async rst pix_x", 64'(a_pix_x), 64'd0);
        check("async rst check", 64'(a_check), 64'd0);
        check("async rst err", 64'(a_err), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("post reset idle", 64'(a_state), 64'd0);

        check("final a queue", 64'(exp_a.size()), 64'd0);
        check("final b queue", 64'(exp_b.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
